// File: rtl/lu_share_arbiter.sv
// lu_share_arbiter: shares one registered 3-input logic unit among requesters.
// Build option: define LU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module lu_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic [NUM_REQ-1:0] req_valid_i,
   output logic [NUM_REQ-1:0] req_ready_o,
   input  logic [NUM_REQ-1:0] req_a_i,
   input  logic [NUM_REQ-1:0] req_b_i,
   input  logic [NUM_REQ-1:0] req_c_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [ID_W-1:0]    rsp_id_o,
   output logic               rsp_x_o,
   output logic               rsp_y_o,
   output logic               rsp_z_o,
   output logic               lu_en_o,
   output logic               lu_a_o,
   output logic               lu_b_o,
   output logic               lu_c_o,
   input  logic               lu_x_i,
   input  logic               lu_y_i,
   input  logic               lu_z_i
);

   localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               a_q, a_d;
   logic               b_q, b_d;
   logic               c_q, c_d;
   logic               x_q, x_d;
   logic               y_q, y_d;
   logic               z_q, z_d;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    win;
   logic               win_vld;

`ifdef LU_ARB_FIXED_PRIO_EN

   // Lowest valid index wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_vld && req_valid_i[k]) begin
            win     = ID_W'(k);
            win_vld = 1'b1;
         end
      end
   end

`else

   localparam logic [ID_W:0] NREQ = (ID_W + 1)'(NUM_REQ);

   logic [ID_W-1:0] rr_q, rr_d;
   logic [ID_W:0]   idx;
   logic [ID_W:0]   nxt;
   logic [ID_W-1:0] rr_nxt;

   // First valid index at or after the pointer, wrapping.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_q} + (ID_W + 1)'(k);
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!win_vld && req_valid_i[idx[ID_W-1:0]]) begin
            win     = idx[ID_W-1:0];
            win_vld = 1'b1;
         end
      end
   end

   // Pointer value following the current winner.
   always_comb begin
      nxt = {1'b0, win} + 1'b1;
      if (nxt >= NREQ) begin
         nxt = '0;
      end
      rr_nxt = nxt[ID_W-1:0];
   end

`endif

   // Next-state, grant and datapath load decisions.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      gnt     = '0;
`ifndef LU_ARB_FIXED_PRIO_EN
      rr_d    = rr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!rst_i && en_i && win_vld) begin
               gnt[win] = 1'b1;
               a_d      = req_a_i[win];
               b_d      = req_b_i[win];
               c_d      = req_c_i[win];
               id_d     = win;
               cnt_d    = '0;
               state_d  = RUN;
`ifndef LU_ARB_FIXED_PRIO_EN
               rr_d     = rr_nxt;
`endif
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               x_d     = lu_x_i;
               y_d     = lu_y_i;
               z_d     = lu_z_i;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         c_q     <= 1'b0;
         x_q     <= 1'b0;
         y_q     <= 1'b0;
         z_q     <= 1'b0;
`ifndef LU_ARB_FIXED_PRIO_EN
         rr_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
`ifndef LU_ARB_FIXED_PRIO_EN
         rr_q    <= rr_d;
`endif
      end
   end

   assign req_ready_o = gnt;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_id_o    = id_q;
   assign rsp_x_o     = x_q;
   assign rsp_y_o     = y_q;
   assign rsp_z_o     = z_q;
   assign lu_en_o     = (state_q == RUN);
   assign lu_a_o      = a_q;
   assign lu_b_o      = b_q;
   assign lu_c_o      = c_q;

endmodule

// File: tb/tb_lu_share_arbiter.sv
// tb_lu_share_arbiter: directed bench with scoreboard and a logic-unit model.
// Optional build: LU_ARB_FIXED_PRIO_EN switches the reference to fixed priority.
module tb_lu_share_arbiter;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         rsp_ready = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [N-1:0] c = '0;
   logic [N-1:0] req_ready;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic         rsp_x, rsp_y, rsp_z;
   logic         lu_en, lu_a, lu_b, lu_c;
   logic [2:0]   st1 = '0;
   logic [2:0]   st2 = '0;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   lu_share_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .en_i(en),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_a_i(a),
      .req_b_i(b),
      .req_c_i(c),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id),
      .rsp_x_o(rsp_x),
      .rsp_y_o(rsp_y),
      .rsp_z_o(rsp_z),
      .lu_en_o(lu_en),
      .lu_a_o(lu_a),
      .lu_b_o(lu_b),
      .lu_c_o(lu_c),
      .lu_x_i(st2[2]),
      .lu_y_i(st2[1]),
      .lu_z_i(st2[0])
   );

   function automatic logic [2:0] lu_f(input logic fa, input logic fb,
                                       input logic fc);
      return {fa ^ fb ^ fc, (fa & fb) | (fa & fc) | (fb & fc), fa | fb | fc};
   endfunction

   // Two-stage registered logic unit.
   always @(posedge clk) begin
      if (lu_en) begin
         st1 <= lu_f(lu_a, lu_b, lu_c);
         st2 <= st1;
      end
   end

   function automatic int exp_win(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grant_step(input string tag, output int w);
      int win;
      w = 0;
      while (req_ready == '0 && w < 20) begin
         tick();
         w++;
      end
      if (req_ready == '0) begin
         chk({tag, "_grant"}, 32'(|req_ready), 1);
         w = -1;
         return;
      end
      win = exp_win(req_valid, ptr_m);
      chk({tag, "_rdy"}, 32'(req_ready), 32'(4'b0001 << win));
      exp_q.push_back({win[1:0], lu_f(a[win], b[win], c[win])});
`ifndef LU_ARB_FIXED_PRIO_EN
      ptr_m = (win + 1) % N;
`endif
      tick();
   endtask

   task automatic finish_rsp(input string tag, input int hold);
      int n;
      logic [4:0] e;
      n = 0;
      rsp_ready = (hold == 0);
      while (!rsp_valid && n < 20) begin
         chk({tag, "_lu_en"}, 32'(lu_en), 1);
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, LAT + 1);
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_lu_off"}, 32'(lu_en), 0);
      chk({tag, "_rdy_resp"}, 32'(req_ready), 0);
      for (int h = 0; h < hold; h++) begin
         chk({tag, "_hold_v"}, 32'(rsp_valid), 1);
         chk({tag, "_hold_f"}, 32'({rsp_id, rsp_x, rsp_y, rsp_z}), 32'(e));
         chk({tag, "_hold_r"}, 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      chk({tag, "_rsp"}, 32'({rsp_id, rsp_x, rsp_y, rsp_z}), 32'(e));
      tick();
      chk({tag, "_clr"}, 32'(rsp_valid), 0);
   endtask

   task automatic txn(input string tag, input int gexp, input int hold);
      int w;
      grant_step(tag, w);
      chk({tag, "_gwait"}, w, gexp);
      finish_rsp(tag, hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int seen;
      // reset state
      tick();
      tick();
      tick();
      chk("rst_rdy", 32'(req_ready), 0);
      chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z}), 0);
      chk("rst_lu", 32'({lu_en, lu_a, lu_b, lu_c}), 0);

      // single requester
      rst = 1'b0;
      en = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      a = 4'b0001;
      b = 4'b0000;
      c = 4'b0000;
      #1;
      grant_step("single", w);
      chk("single_gwait", w, 0);
      req_valid = '0;
      chk("single_ops", 32'({lu_en, lu_a, lu_b, lu_c}), 32'(4'b1100));
      finish_rsp("single", 0);

      // round robin from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ptr_m = 0;
      req_valid = 4'b1111;
      a = 4'b0101;
      b = 4'b0011;
      c = 4'b0110;
      #1;
      for (int i = 0; i < 5; i++) begin
         txn("rr", 0, 0);
      end

      // two valid requesters
      req_valid = 4'b1010;
      a = 4'b1010;
      b = 4'b1000;
      c = 4'b0010;
      #1;
      txn("pair", 0, 0);
      txn("pair", 0, 0);
      txn("pair", 0, 0);

      // backpressure then immediate regrant
      req_valid = 4'b1111;
      a = 4'b1111;
      b = 4'b0110;
      c = 4'b1001;
      #1;
      txn("bp", 0, 5);
      txn("bp_next", 0, 0);

      // enable gating
      en = 1'b0;
      req_valid = 4'b0100;
      a = 4'b0100;
      b = 4'b0100;
      c = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("en_off", 32'(req_ready), 0);
      end
      en = 1'b1;
      #1;
      grant_step("en", w);
      chk("en_gwait", w, 0);
      en = 1'b0;
      finish_rsp("en", 0);
      chk("en_off2", 32'(req_ready), 0);
      en = 1'b1;

      // reset in the middle of RUN
      req_valid = 4'b1111;
      a = 4'b1111;
      b = 4'b1111;
      c = 4'b1111;
      #1;
      grant_step("mrst", w);
      rst = 1'b1;
      tick();
      chk("mrst_rdy", 32'(req_ready), 0);
      chk("mrst_rsp", 32'({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z}), 0);
      chk("mrst_lu", 32'({lu_en, lu_a, lu_b, lu_c}), 0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      ptr_m = 0;
      rst = 1'b0;
      req_valid = '0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid) seen++;
      end
      chk("mrst_norsp", seen, 0);
      req_valid = 4'b1111;
      #1;
      txn("after_rst", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
